// File: rtl/pic_pkg.sv
// Shared types and command encodings for the 8259A-compatible interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pic_pkg;

    typedef enum logic [2:0] {
        UNINIT,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } init_state_t;

    // Tracks the two INTA pulses of an acknowledge cycle.
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_ACK1,
        PH_WAIT2,
        PH_ACK2
    } inta_phase_t;

    // OCW2 {R, SL, EOI} codes
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NSEOI        = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SEOI         = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NSEOI    = 3'b101;
    localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
    localparam logic [2:0] OCW2_ROT_SEOI     = 3'b111;

    localparam logic RD_SEL_IRR = 1'b0;
    localparam logic RD_SEL_ISR = 1'b1;

    // Lowest-priority pointer value giving fixed IR0-highest ordering.
    localparam logic [2:0] LP_FIXED = 3'd7;

    // 0 is the highest-priority rank for the given lowest-priority pointer.
    function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lp);
        return lvl - lp - 3'd1;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Picks the highest-priority unmasked request and the highest in-service level.
// Latency: purely combinational.
// Backpressure: none.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic [7:0] isr,
    input  logic [2:0] lp,
    output logic [2:0] win_lvl,
    output logic       win_vld,
    output logic [2:0] isr_lvl,
    output logic       isr_vld
);

    logic [7:0] req;
    logic [2:0] lvl;

    assign req = irr & ~imr;

    // Scan from lowest to highest priority so the last hit wins.
    always_comb begin
        win_lvl = '0;
        win_vld = 1'b0;
        isr_lvl = '0;
        isr_vld = 1'b0;
        lvl     = '0;
        for (int i = 7; i >= 0; i--) begin
            lvl = lp + 3'd1 + 3'(i);
            if (req[lvl]) begin
                win_lvl = lvl;
                win_vld = 1'b1;
            end
            if (isr[lvl]) begin
                isr_lvl = lvl;
                isr_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pic_8259_core.sv
// 8259A-compatible interrupt controller (8086 mode); PIC_ROTATION_EN adds OCW2 rotation.
// Latency: INT_Flag one cycle after IRR/ISR change; register reads combinational.
// Backpressure: none; CPU strobes and INTA pulses are accepted whenever they arrive.
module pic_8259_core
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    inout  wire  [7:0] data_Bus,
    inout  wire  [2:0] cascade_lines,
    input  logic       write_flag,
    input  logic       read_flag,
    input  logic       chip_select,
    input  logic       A0,
    input  logic       sp,
    input  logic       INTA,
    input  logic [7:0] interrupt_requests,
    output logic       INT_Flag
);

    init_state_t st_q, st_d;
    inta_phase_t ph_q, ph_d;

    logic       wr_d, inta_d;
    logic [7:0] ir_d;
    logic [7:0] irr_q, isr_q, imr_q, icw3_q;
    logic [7:0] irr_n, isr_n;
    logic [4:0] t_q;
    logic       ltim_q, sngl_q, ic4_q, aeoi_q, ris_q;
    logic [2:0] lvl_q;
    logic       own_q, cas_q, spur_q, int_q;

    logic [7:0] din, rd_dat;
    logic       wr_commit, is_icw1, wr_a1, is_ocw2, is_ocw3;
    logic [2:0] ocw2_code;
    logic       inta_fall, inta_rise, is_slave;
    logic       first_ack, master_ack, slave_match, aeoi_clr, cas_sel;
    logic [2:0] win_lvl, isr_lvl, lp_q;
    logic       win_vld, isr_vld, int_cond;
    logic       vec_drv, cas_drv, rd_drv;

    assign din       = data_Bus;
    assign wr_commit = ~chip_select & ~wr_d & write_flag;
    assign is_icw1   = wr_commit & ~A0 & din[4];
    assign wr_a1     = wr_commit & A0;
    assign is_ocw2   = wr_commit & ~A0 & (din[4:3] == 2'b00) & (st_q == READY);
    assign is_ocw3   = wr_commit & ~A0 & (din[4:3] == 2'b01) & (st_q == READY);
    assign ocw2_code = din[7:5];

    assign inta_fall = inta_d & ~INTA;
    assign inta_rise = ~inta_d & INTA;
    // Single mode ignores sp; only a cascaded part with sp=0 acts as a slave.
    assign is_slave  = ~sp & ~sngl_q;

    pic_priority_resolver u_resolver (
        .irr     (irr_q),
        .imr     (imr_q),
        .isr     (isr_q),
        .lp      (lp_q),
        .win_lvl (win_lvl),
        .win_vld (win_vld),
        .isr_lvl (isr_lvl),
        .isr_vld (isr_vld)
    );

    assign int_cond = win_vld &
                      (~isr_vld | (prio_rank(win_lvl, lp_q) < prio_rank(isr_lvl, lp_q)));

    assign first_ack   = (ph_q == PH_IDLE) & inta_fall & (st_q == READY) & ~is_icw1;
    assign master_ack  = first_ack & ~is_slave & win_vld;
    assign slave_match = (ph_q == PH_ACK1) & inta_rise & is_slave & win_vld & ~is_icw1 &
                         (cascade_lines == icw3_q[2:0]);
    assign aeoi_clr    = (ph_q == PH_ACK2) & inta_rise & aeoi_q & ~spur_q & ~is_icw1;
    assign cas_sel     = win_vld & sp & ~sngl_q & icw3_q[win_lvl];

    always_comb begin
        st_d = st_q;
        ph_d = ph_q;
        if (is_icw1) begin
            st_d = WAIT_ICW2;
        end else if (wr_a1) begin
            case (st_q)
                WAIT_ICW2: st_d = !sngl_q ? WAIT_ICW3 : (ic4_q ? WAIT_ICW4 : READY);
                WAIT_ICW3: st_d = ic4_q ? WAIT_ICW4 : READY;
                WAIT_ICW4: st_d = READY;
                default:   st_d = st_q;
            endcase
        end

        if (is_icw1) begin
            ph_d = PH_IDLE;
        end else begin
            case (ph_q)
                PH_IDLE:  if (inta_fall && st_q == READY) ph_d = PH_ACK1;
                PH_ACK1:  if (inta_rise) ph_d = PH_WAIT2;
                PH_WAIT2: if (inta_fall) ph_d = PH_ACK2;
                PH_ACK2:  if (inta_rise) ph_d = PH_IDLE;
                default:  ph_d = PH_IDLE;
            endcase
        end
    end

    always_comb begin
        irr_n = ltim_q ? interrupt_requests : (irr_q | (interrupt_requests & ~ir_d));
        isr_n = isr_q;
        if (master_ack || slave_match) begin
            isr_n[win_lvl] = 1'b1;
            irr_n[win_lvl] = 1'b0;
        end
        if (aeoi_clr) begin
            isr_n[lvl_q] = 1'b0;
        end
        // Rotating EOIs clear exactly like their plain counterparts.
        if (is_ocw2) begin
            if ((ocw2_code == OCW2_NSEOI || ocw2_code == OCW2_ROT_NSEOI) && isr_vld) begin
                isr_n[isr_lvl] = 1'b0;
            end
            if (ocw2_code == OCW2_SEOI || ocw2_code == OCW2_ROT_SEOI) begin
                isr_n[din[2:0]] = 1'b0;
            end
        end
        if (is_icw1) begin
            irr_n = '0;
            isr_n = '0;
        end
    end

`ifdef PIC_ROTATION_EN
    logic [2:0] lp_n;
    logic       rot_aeoi_q, rot_aeoi_n;

    always_comb begin
        lp_n       = lp_q;
        rot_aeoi_n = rot_aeoi_q;
        if (aeoi_clr && rot_aeoi_q) begin
            lp_n = lvl_q;
        end
        if (is_ocw2) begin
            case (ocw2_code)
                OCW2_ROT_NSEOI:    if (isr_vld) lp_n = isr_lvl;
                OCW2_ROT_SEOI,
                OCW2_SET_PRI:      lp_n = din[2:0];
                OCW2_ROT_AEOI_SET: rot_aeoi_n = 1'b1;
                OCW2_ROT_AEOI_CLR: rot_aeoi_n = 1'b0;
                default:           lp_n = lp_q;
            endcase
        end
        if (is_icw1) begin
            lp_n       = LP_FIXED;
            rot_aeoi_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lp_q       <= LP_FIXED;
            rot_aeoi_q <= 1'b0;
        end else begin
            lp_q       <= lp_n;
            rot_aeoi_q <= rot_aeoi_n;
        end
    end
`else
    assign lp_q = LP_FIXED;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= UNINIT;
            ph_q   <= PH_IDLE;
            wr_d   <= 1'b1;
            inta_d <= 1'b1;
            ir_d   <= '0;
            irr_q  <= '0;
            isr_q  <= '0;
            imr_q  <= '0;
            icw3_q <= '0;
            t_q    <= '0;
            ltim_q <= 1'b0;
            sngl_q <= 1'b0;
            ic4_q  <= 1'b0;
            aeoi_q <= 1'b0;
            ris_q  <= RD_SEL_IRR;
            lvl_q  <= '0;
            own_q  <= 1'b0;
            cas_q  <= 1'b0;
            spur_q <= 1'b0;
            int_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            ph_q   <= ph_d;
            wr_d   <= write_flag;
            inta_d <= INTA;
            ir_d   <= interrupt_requests;
            irr_q  <= irr_n;
            isr_q  <= isr_n;
            int_q  <= (st_q == READY) & int_cond;
            if (is_icw1) begin
                ltim_q <= din[3];
                sngl_q <= din[1];
                ic4_q  <= din[0];
                imr_q  <= '0;
                ris_q  <= RD_SEL_IRR;
                aeoi_q <= 1'b0;
                own_q  <= 1'b0;
                cas_q  <= 1'b0;
            end else begin
                if (wr_a1) begin
                    case (st_q)
                        WAIT_ICW2: t_q    <= din[7:3];
                        WAIT_ICW3: icw3_q <= din;
                        WAIT_ICW4: aeoi_q <= din[1];
                        READY:     imr_q  <= din;
                        default:   ;
                    endcase
                end
                if (is_ocw3 && din[1]) begin
                    ris_q <= din[0];
                end
                // A slave tracks every cycle but owns none until its ID is seen.
                if (first_ack) begin
                    if (is_slave) begin
                        lvl_q  <= 3'd7;
                        spur_q <= 1'b1;
                        own_q  <= 1'b0;
                        cas_q  <= 1'b0;
                    end else begin
                        lvl_q  <= win_vld ? win_lvl : 3'd7;
                        spur_q <= ~win_vld;
                        own_q  <= ~cas_sel;
                        cas_q  <= cas_sel;
                    end
                end
                if (slave_match) begin
                    lvl_q  <= win_lvl;
                    spur_q <= 1'b0;
                    own_q  <= 1'b1;
                end
                if (ph_q == PH_ACK2 && inta_rise) begin
                    own_q <= 1'b0;
                    cas_q <= 1'b0;
                end
            end
        end
    end

    assign rd_dat  = A0 ? imr_q : ((ris_q == RD_SEL_ISR) ? isr_q : irr_q);
    assign vec_drv = (ph_q == PH_ACK2) & own_q & ~INTA;
    assign cas_drv = cas_q & (ph_q != PH_IDLE);
    assign rd_drv  = ~chip_select & ~read_flag;

    assign data_Bus      = vec_drv ? {t_q, lvl_q} : (rd_drv ? rd_dat : 8'hzz);
    assign cascade_lines = cas_drv ? lvl_q : 3'bzzz;
    assign INT_Flag      = int_q;

endmodule

// File: tb/tb_pic_8259_core.sv
// Randomised bench for a master/slave pair of pic_8259_core against a behavioural priority model.
module tb_pic_8259_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0, inta_n = 1'b1;
    logic       cs_m = 1'b1, cs_s = 1'b1;
    logic [7:0] ir_m = '0, ir_s = '0;
    logic       tb_drv = 1'b0;
    logic [7:0] tb_dat = '0;
    logic       casc_en = 1'b0;
    wire  [7:0] data_bus;
    wire  [2:0] cas;
    wire        int_m, int_s;
    wire  [7:0] ir_m_eff;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign data_bus = tb_drv ? tb_dat : 8'hzz;
    pullup (data_bus);
    pullup (cas);
    assign ir_m_eff = ir_m | (casc_en ? {6'b0, int_s, 1'b0} : 8'h00);

    pic_8259_core u_mst (
        .clk(clk), .rst(rst), .data_Bus(data_bus), .cascade_lines(cas),
        .write_flag(wr_n), .read_flag(rd_n), .chip_select(cs_m), .A0(a0),
        .sp(1'b1), .INTA(inta_n), .interrupt_requests(ir_m_eff), .INT_Flag(int_m)
    );

    pic_8259_core u_slv (
        .clk(clk), .rst(rst), .data_Bus(data_bus), .cascade_lines(cas),
        .write_flag(wr_n), .read_flag(rd_n), .chip_select(cs_s), .A0(a0),
        .sp(1'b0), .INTA(inta_n), .interrupt_requests(ir_s), .INT_Flag(int_s)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic s, input logic a, input logic [7:0] d);
        @(negedge clk);
        a0 = a; tb_dat = d; tb_drv = 1'b1; wr_n = 1'b0;
        if (s) cs_s = 1'b0; else cs_m = 1'b0;
        @(negedge clk);
        wr_n = 1'b1;
        @(negedge clk);
        cs_m = 1'b1; cs_s = 1'b1; tb_drv = 1'b0;
    endtask

    task automatic rd(input logic s, input logic a, output logic [7:0] d);
        @(negedge clk);
        a0 = a; rd_n = 1'b0;
        if (s) cs_s = 1'b0; else cs_m = 1'b0;
        #1 d = data_bus;
        @(negedge clk);
        rd_n = 1'b1; cs_m = 1'b1; cs_s = 1'b1;
    endtask

    task automatic init_pic(input logic s, input logic [7:0] i1, input logic [7:0] i2,
                            input logic [7:0] i3, input logic [7:0] i4);
        wr(s, 1'b0, i1);
        wr(s, 1'b1, i2);
        if (!i1[1]) wr(s, 1'b1, i3);
        if (i1[0])  wr(s, 1'b1, i4);
    endtask

    task automatic pulse_ir(input logic s, input logic [7:0] m);
        @(negedge clk);
        if (s) ir_s = ir_s | m; else ir_m = ir_m | m;
        idle(2);
        if (s) ir_s = ir_s & ~m; else ir_m = ir_m & ~m;
        idle(3);
    endtask

    // Two INTA pulses; bus values are captured while the second pulse is low.
    task automatic inta(output logic [7:0] v, output logic [2:0] c);
        @(negedge clk); inta_n = 1'b0;
        idle(2);        inta_n = 1'b1;
        idle(2);        inta_n = 1'b0;
        @(negedge clk);
        c = cas; v = data_bus;
        @(negedge clk); inta_n = 1'b1;
        idle(2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; casc_en = 1'b0; ir_m = '0; ir_s = '0;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    // Reference: fixed priority, IR0 highest; -1 when nothing unmasked is pending.
    function automatic int model_win(input logic [7:0] pend, input logic [7:0] mask);
        for (int i = 0; i < 8; i++)
            if (pend[i] && !mask[i]) return i;
        return -1;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] d, v, t, mask, pend, r;
        logic [2:0] c;
        int         w, la, lb, lv;

        do_reset();
        chk("rst_int_m", int_m, 0);
        chk("rst_int_s", int_s, 0);
        chk("rst_bus_released", data_bus, 8'hFF);
        chk("rst_cas_released", cas, 3'h7);
        rd(0, 1, d); chk("rst_imr", d, 8'h00);
        rd(0, 0, d); chk("rst_irr", d, 8'h00);

        // Full four-word init on a cascaded master, then IMR read-back.
        init_pic(0, 8'h11, 8'h08, 8'h3F, 8'h00);
        wr(0, 1, 8'h00);
        rd(0, 1, d); chk("init_imr", d, 8'h00);
        for (int k = 0; k < 3; k++) begin
            r = 8'($urandom);
            wr(0, 1, r);
            rd(0, 1, d); chk("imr_readback", d, r);
        end

        // Test-plan single master with AEOI and IR3.
        do_reset();
        init_pic(0, 8'h13, 8'h20, 8'h00, 8'h02);
        pulse_ir(0, 8'h08); idle(2);
        chk("ir3_int", int_m, 1);
        inta(v, c);
        chk("ir3_vector", v, 8'h23);
        wr(0, 0, 8'h0B);
        rd(0, 0, d); chk("ir3_isr_aeoi", d, 8'h00);

        // Random requests and masks, served in priority order with AEOI.
        for (int it = 0; it < 6; it++) begin
            do_reset();
            t = 8'($urandom);
            init_pic(0, 8'h13, t, 8'h00, 8'h02);
            mask = 8'($urandom) & 8'($urandom);
            pend = 8'($urandom_range(1, 255));
            wr(0, 1, mask);
            pulse_ir(0, pend);
            rd(0, 0, d); chk("rand_irr", d, pend);
            for (int k = 0; k < 8; k++) begin
                w = model_win(pend, mask);
                if (w < 0) break;
                chk("rand_int", int_m, 1);
                inta(v, c);
                chk("rand_vector", v, {t[7:3], 3'(w)});
                pend[w] = 1'b0;
                idle(1);
            end
            chk("rand_int_idle", int_m, 0);
            rd(0, 0, d); chk("rand_irr_left", d, pend);
            wr(0, 0, 8'h0B);
            rd(0, 0, d); chk("rand_isr", d, 8'h00);
        end

        // Two pending levels, fully nested, released by EOI.
        for (int it = 0; it < 4; it++) begin
            do_reset();
            t = 8'($urandom);
            if (it == 0) begin la = 2; lb = 5; end
            else begin
                la = $urandom_range(0, 6);
                lb = $urandom_range(la + 1, 7);
            end
            init_pic(0, 8'h13, t, 8'h00, 8'h00);
            pulse_ir(0, 8'(1 << la) | 8'(1 << lb)); idle(2);
            chk("nest_int_a", int_m, 1);
            inta(v, c);
            chk("nest_vec_a", v, {t[7:3], 3'(la)});
            chk("nest_int_blocked", int_m, 0);
            wr(0, 0, 8'h0B);
            rd(0, 0, d); chk("nest_isr_a", d, 8'(1 << la));
            if (it[0]) wr(0, 0, 8'h60 | 8'(la));
            else       wr(0, 0, 8'h20);
            idle(2);
            rd(0, 0, d); chk("nest_isr_eoi", d, 8'h00);
            chk("nest_int_b", int_m, 1);
            inta(v, c);
            chk("nest_vec_b", v, {t[7:3], 3'(lb)});
            wr(0, 0, 8'h20); idle(2);
            rd(0, 0, d); chk("nest_isr_done", d, 8'h00);
            chk("nest_int_done", int_m, 0);
        end

        // Master/slave cascade through master IR1.
        for (int it = 0; it < 3; it++) begin
            do_reset();
            lv = (it == 0) ? 4 : $urandom_range(0, 7);
            casc_en = 1'b1;
            init_pic(0, 8'h11, 8'h08, 8'h02, 8'h00);
            init_pic(1, 8'h11, 8'h10, 8'h01, 8'h00);
            pulse_ir(1, 8'(1 << lv)); idle(4);
            chk("casc_int_m", int_m, 1);
            inta(v, c);
            chk("casc_lines", c, 3'd1);
            chk("casc_vector", v, 8'h10 | 8'(lv));
            wr(0, 0, 8'h0B);
            rd(0, 0, d); chk("casc_isr_m", d, 8'h02);
            wr(1, 0, 8'h0B);
            rd(1, 0, d); chk("casc_isr_s", d, 8'(1 << lv));
            wr(1, 0, 8'h20);
            wr(0, 0, 8'h20); idle(3);
            chk("casc_int_m_done", int_m, 0);
            rd(1, 0, d); chk("casc_isr_s_done", d, 8'h00);
        end

        // Masked IR0 and read-select switching.
        do_reset();
        init_pic(0, 8'h13, 8'h40, 8'h00, 8'h00);
        wr(0, 1, 8'hFF);
        pulse_ir(0, 8'h01); idle(2);
        chk("mask_int", int_m, 0);
        wr(0, 0, 8'h0A);
        rd(0, 0, d); chk("mask_irr", d, 8'h01);
        wr(0, 0, 8'h0B);
        rd(0, 0, d); chk("mask_isr", d, 8'h00);

        // Spurious acknowledge with nothing pending.
        do_reset();
        t = 8'($urandom);
        init_pic(0, 8'h13, t, 8'h00, 8'h00);
        inta(v, c);
        chk("spur_vector", v, {t[7:3], 3'd7});
        wr(0, 0, 8'h0B);
        rd(0, 0, d); chk("spur_isr", d, 8'h00);

        // Level-triggered IRR follows the inputs.
        do_reset();
        init_pic(0, 8'h1B, 8'h50, 8'h00, 8'h00);
        for (int k = 0; k < 3; k++) begin
            r = 8'($urandom);
            @(negedge clk); ir_m = r;
            idle(3);
            rd(0, 0, d); chk("level_irr", d, r);
            chk("level_int", int_m, (r != 8'h00));
        end
        @(negedge clk); ir_m = '0;

        // Reset asserted during the second INTA pulse.
        do_reset();
        t = 8'($urandom);
        lv = $urandom_range(0, 7);
        init_pic(0, 8'h13, t, 8'h00, 8'h02);
        pulse_ir(0, 8'(1 << lv)); idle(2);
        @(negedge clk); inta_n = 1'b0;
        idle(2);        inta_n = 1'b1;
        idle(2);        inta_n = 1'b0;
        @(negedge clk);
        chk("rstmid_vector", data_bus, {t[7:3], 3'(lv)});
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_bus", data_bus, 8'hFF);
        chk("rstmid_int", int_m, 0);
        rst = 1'b0; inta_n = 1'b1;
        idle(2);
        wr(0, 1, 8'h55);
        rd(0, 1, d); chk("rstmid_uninit_imr", d, 8'h00);
        pulse_ir(0, 8'h08); idle(2);
        chk("rstmid_uninit_int", int_m, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
